// File: rtl/mmio_pkg.sv
// Shared register-map helpers for the MMIO port bank.
package mmio_pkg;

    localparam int MMIO_MAX_OUT = 8;

    function automatic int mmio_nreg(input int nout, input int nin);
        return nout + nin + 3;
    endfunction

    function automatic int OFF_STATUS(input int nout, input int nin);
        return nout + nin;
    endfunction

    function automatic int OFF_PAD_LEVEL(input int nout, input int nin);
        return nout + nin + 1;
    endfunction

    function automatic int OFF_PAD_EDGE(input int nout, input int nin);
        return nout + nin + 2;
    endfunction

    function automatic bit mmio_params_ok(
        input int nout,
        input int nin,
        input int dw,
        input int pw
    );
        return (nout >= 1) && (nout <= MMIO_MAX_OUT) &&
               (nin >= 1) && (nin <= dw / 2) &&
               (pw >= 1) && (pw <= dw);
    endfunction

endpackage

// File: rtl/mmio_in_channel.sv
// One captured input channel: data, valid and sticky overrun.
module mmio_in_channel
    import mmio_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] cap_data_i,
    input  logic              rd_clr_i,
    input  logic              ovr_clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              ovr_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              ovr_set;

    // A read in the capture cycle consumes the old word, so no overrun.
    assign ovr_set = cap_i && valid_q && !rd_clr_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (cap_i) begin
            data_d  = cap_data_i;
            valid_d = 1'b1;
        end else if (rd_clr_i) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_set || (ovr_q && !ovr_clr_i);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of output registers, input captures and gamepad.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
    parameter int              NUM_OUT   = 2,
    parameter int              NUM_IN    = 2,
    parameter int              PAD_W     = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [ADDR_W-1:0]         Addr,
    input  logic                      WriteEn,
    input  logic                      ReadEn,
    input  logic [DATA_W-1:0]         WData,
    output logic                      Hit,
    output logic [DATA_W-1:0]         RData,
    output logic                      RValid,
    output logic [NUM_OUT*DATA_W-1:0] OutRegs,
    input  logic [NUM_IN*DATA_W-1:0]  InData,
    input  logic [NUM_IN-1:0]         InValid,
    input  logic [PAD_W-1:0]          GamePad,
    output logic                      Irq
);

    localparam int NREG = mmio_nreg(NUM_OUT, NUM_IN);
    localparam logic [ADDR_W-1:0] A_NREG = ADDR_W'(NREG);
    localparam logic [ADDR_W-1:0] A_STAT =
        ADDR_W'(OFF_STATUS(NUM_OUT, NUM_IN));
    localparam logic [ADDR_W-1:0] A_LVL =
        ADDR_W'(OFF_PAD_LEVEL(NUM_OUT, NUM_IN));
    localparam logic [ADDR_W-1:0] A_EDGE =
        ADDR_W'(OFF_PAD_EDGE(NUM_OUT, NUM_IN));

    if (!mmio_params_ok(NUM_OUT, NUM_IN, DATA_W, PAD_W)) begin : g_bad
        $error("mmio_port_bank: parameter out of range");
    end

    logic [ADDR_W-1:0] off;
    logic              wr, rd;

    assign off = Addr - BASE_ADDR;
    assign Hit = (Addr >= BASE_ADDR) && (off < A_NREG);
    assign wr  = WriteEn && Hit;
    assign rd  = ReadEn && Hit;

    logic [NUM_OUT*DATA_W-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (wr && off == ADDR_W'(k))
                out_d[k*DATA_W +: DATA_W] = WData;
        end
    end

    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid, in_ovr;
    logic [NUM_IN-1:0]        rd_clr, ovr_clr;

    always_comb begin
        rd_clr  = '0;
        ovr_clr = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            rd_clr[j]  = rd && off == ADDR_W'(NUM_OUT + j);
            ovr_clr[j] = wr && off == A_STAT && WData[NUM_IN + j];
        end
    end

    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        mmio_in_channel #(.DATA_W(DATA_W)) u_ch (
            .Clock      (Clock),
            .Reset      (Reset),
            .cap_i      (InValid[j]),
            .cap_data_i (InData[j*DATA_W +: DATA_W]),
            .rd_clr_i   (rd_clr[j]),
            .ovr_clr_i  (ovr_clr[j]),
            .data_o     (in_data[j*DATA_W +: DATA_W]),
            .valid_o    (in_valid[j]),
            .ovr_o      (in_ovr[j])
        );
    end

    logic [PAD_W-1:0] sync1_q, sync2_q, prev_q;
    logic [PAD_W-1:0] edge_q, edge_d, edge_clr;

    // A new rising edge beats a same-cycle W1C of that flag.
    always_comb begin
        edge_clr = '0;
        if (wr && off == A_EDGE)
            edge_clr = WData[PAD_W-1:0];
        edge_d = (sync2_q & ~prev_q) | (edge_q & ~edge_clr);
    end

    logic [DATA_W-1:0] status, pad_lvl, pad_edge, rmux;

    always_comb begin
        status                   = '0;
        status[NUM_IN-1:0]       = in_valid;
        status[NUM_IN +: NUM_IN] = in_ovr;
        pad_lvl                  = '0;
        pad_lvl[PAD_W-1:0]       = sync2_q;
        pad_edge                 = '0;
        pad_edge[PAD_W-1:0]      = edge_q;
    end

    always_comb begin
        rmux = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (off == ADDR_W'(k))
                rmux = out_q[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (off == ADDR_W'(NUM_OUT + j))
                rmux = in_data[j*DATA_W +: DATA_W];
        end
        if (off == A_STAT)
            rmux = status;
        if (off == A_LVL)
            rmux = pad_lvl;
        if (off == A_EDGE)
            rmux = pad_edge;
    end

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, irq_q;

    assign rdata_d = rd ? rmux : rdata_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            sync1_q  <= GamePad;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_q   <= edge_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd;
            irq_q    <= (|in_valid) || (|edge_q);
        end
    end

    assign OutRegs = out_q;
    assign RData   = rdata_q;
    assign RValid  = rvalid_q;
    assign Irq     = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Scoreboard bench for mmio_port_bank with default parameters.
module tb_mmio_port_bank;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Addr = '0;
    logic        WriteEn = 1'b0;
    logic        ReadEn = 1'b0;
    logic [15:0] WData = '0;
    logic        Hit;
    logic [15:0] RData;
    logic        RValid;
    logic [31:0] OutRegs;
    logic [31:0] InData = '0;
    logic [1:0]  InValid = '0;
    logic [7:0]  GamePad = '0;
    logic        Irq;

    mmio_port_bank dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Addr    (Addr),
        .WriteEn (WriteEn),
        .ReadEn  (ReadEn),
        .WData   (WData),
        .Hit     (Hit),
        .RData   (RData),
        .RValid  (RValid),
        .OutRegs (OutRegs),
        .InData  (InData),
        .InValid (InValid),
        .GamePad (GamePad),
        .Irq     (Irq)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_bad = 0;
    string       sb_tag[$];
    logic [15:0] sb_exp[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (RValid === 1'b1) begin
            if (sb_exp.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk(sb_tag.pop_front(), 32'(RData),
                    32'(sb_exp.pop_front()));
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic we,
                         input logic re, input logic [15:0] wd,
                         input logic [1:0] inv, input logic [31:0] ind);
        Addr    = a;
        WriteEn = we;
        ReadEn  = re;
        WData   = wd;
        InValid = inv;
        if (inv != 2'b00) InData = ind;
        @(negedge Clock);
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
        InValid = 2'b00;
    endtask

    task automatic idle();
        drive(16'h0000, 1'b0, 1'b0, 16'h0, 2'b00, 32'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(a, 1'b1, 1'b0, d, 2'b00, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a,
                      input logic [15:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
        drive(a, 1'b0, 1'b1, 16'h0, 2'b00, 32'h0);
    endtask

    task automatic cap(input int j, input logic [15:0] d);
        logic [31:0] v;
        v = 32'(d) << (16 * j);
        drive(16'h0000, 1'b0, 1'b0, 16'h0, 2'(1 << j), v);
    endtask

    task automatic miss(input string tag, input logic [15:0] a);
        Addr   = a;
        ReadEn = 1'b1;
        #1 chk({tag, "_hit"}, 32'(Hit), 32'd0);
        @(negedge Clock);
        ReadEn = 1'b0;
        chk({tag, "_rvalid"}, 32'(RValid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clock);
        chk("rst_rvalid", 32'(RValid), 32'd0);
        chk("rst_out", OutRegs, 32'h0);
        chk("rst_irq", 32'(Irq), 32'd0);
        Reset = 1'b0;

        wr(16'hFF01, 16'h1234);
        chk("out1_wr", OutRegs, 32'h1234_0000);
        wr(16'hFF00, 16'hA5A5);
        rd("rd_out1", 16'hFF01, 16'h1234);
        rd("rd_out0", 16'hFF00, 16'hA5A5);

        cap(0, 16'h00AB);
        chk("irq_cap_1cyc", 32'(Irq), 32'd0);
        rd("stat_v0", 16'hFF04, 16'h0001);
        chk("irq_cap_2cyc", 32'(Irq), 32'd1);
        rd("rd_in0", 16'hFF02, 16'h00AB);
        rd("stat_clr", 16'hFF04, 16'h0000);

        cap(1, 16'h1111);
        cap(1, 16'h2222);
        rd("stat_ovr", 16'hFF04, 16'h000A);
        wr(16'hFF04, 16'h0008);
        rd("stat_w1c", 16'hFF04, 16'h0002);
        rd("rd_in1", 16'hFF03, 16'h2222);
        rd("stat_zero", 16'hFF04, 16'h0000);

        cap(1, 16'h3333);
        drive(16'hFF04, 1'b1, 1'b0, 16'h0008, 2'b10, 32'h3434_0000);
        rd("ovr_setwins", 16'hFF04, 16'h000A);
        rd("rd_in1_b", 16'hFF03, 16'h3434);
        wr(16'hFF04, 16'h0008);
        rd("stat_zero_b", 16'hFF04, 16'h0000);

        cap(0, 16'h0011);
        sb_tag.push_back("rd_cap_old");
        sb_exp.push_back(16'h0011);
        drive(16'hFF02, 1'b0, 1'b1, 16'h0, 2'b01, 32'h0000_0055);
        rd("stat_rdcap", 16'hFF04, 16'h0001);
        rd("rd_cap_new", 16'hFF02, 16'h0055);
        rd("stat_zero_c", 16'hFF04, 16'h0000);

        sb_tag.push_back("rw_old");
        sb_exp.push_back(16'hA5A5);
        drive(16'hFF00, 1'b1, 1'b1, 16'hBEEF, 2'b00, 32'h0);
        chk("rw_out", OutRegs, 32'h1234_BEEF);
        rd("rw_new", 16'hFF00, 16'hBEEF);
        wr(16'hFF02, 16'hFFFF);
        wr(16'hFF05, 16'hFFFF);
        wr(16'hFF07, 16'h7777);
        wr(16'hFEFF, 16'h6666);
        chk("wr_miss_out", OutRegs, 32'h1234_BEEF);
        rd("ro_in0", 16'hFF02, 16'h0055);
        idle();
        idle();
        chk("rdata_hold", 32'(RData), 32'h0055);

        GamePad = 8'h08;
        rd("edge_c1", 16'hFF06, 16'h0000);
        rd("lvl_c2", 16'hFF05, 16'h0000);
        rd("edge_c3", 16'hFF06, 16'h0000);
        chk("irq_pad_pre", 32'(Irq), 32'd0);
        rd("edge_c4", 16'hFF06, 16'h0008);
        chk("irq_pad", 32'(Irq), 32'd1);
        rd("lvl_set", 16'hFF05, 16'h0008);
        wr(16'hFF06, 16'h0008);
        rd("edge_w1c", 16'hFF06, 16'h0000);
        chk("irq_pad_clr", 32'(Irq), 32'd0);

        GamePad = 8'h00;
        repeat (3) idle();
        GamePad = 8'h08;
        idle();
        idle();
        wr(16'hFF06, 16'h0008);
        rd("edge_setwins", 16'hFF06, 16'h0008);
        wr(16'hFF06, 16'h0008);

        Addr = 16'hFF06;
        #1 chk("hit_last", 32'(Hit), 32'd1);
        Addr = 16'hFF00;
        #1 chk("hit_first", 32'(Hit), 32'd1);
        miss("miss_lo", 16'hFEFF);
        miss("miss_hi", 16'hFF07);

        GamePad = 8'h00;
        cap(0, 16'h00CC);
        repeat (3) idle();
        chk("irq_pre_rst", 32'(Irq), 32'd1);
        Addr   = 16'hFF00;
        ReadEn = 1'b1;
        Reset  = 1'b1;
        @(negedge Clock);
        ReadEn = 1'b0;
        chk("rst_mid_rvalid", 32'(RValid), 32'd0);
        chk("rst_mid_out", OutRegs, 32'h0);
        chk("rst_mid_irq", 32'(Irq), 32'd0);
        chk("rst_mid_rdata", 32'(RData), 32'h0);
        Reset = 1'b0;
        rd("post_stat", 16'hFF04, 16'h0000);
        rd("post_in0", 16'hFF02, 16'h0000);
        rd("post_edge", 16'hFF06, 16'h0000);
        rd("post_out1", 16'hFF01, 16'h0000);
        idle();
        idle();
        chk("sb_drain", 32'(sb_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_port_bank.md
# mmio_port_bank

Parametrised memory-mapped I/O register bank that sits between the CPU data bus and the board peripherals (VGA pointer registers, serial receiver, gamepad). It generalises the CPU's fixed VGA start/row registers and raw serial/gamepad inputs into N writable output registers, M captured input channels with valid/overrun tracking, and a synchronised gamepad with sticky edge events. All accesses are single-cycle writes and one-cycle-latency registered reads.

## Interface
- DATA_W, 16, bus and register width
- ADDR_W, 16, bus address width
- BASE_ADDR, 16'hFF00, word address of register 0
- NUM_OUT, 2, number of R/W output registers (1..8)
- NUM_IN, 2, number of input capture channels (1..DATA_W/2)
- PAD_W, 8, gamepad width (<= DATA_W)

- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Addr  in  ADDR_W  bus word address
- WriteEn  in  1  write strobe, qualified by Hit
- ReadEn  in  1  read strobe, qualified by Hit
- WData  in  DATA_W  write data
- Hit  out  1  combinational: Addr within BASE_ADDR..BASE_ADDR+NREG-1
- RData  out  DATA_W  registered read data
- RValid  out  1  high one cycle after an accepted read
- OutRegs  out  NUM_OUT*DATA_W  output registers, channel k at [k*DATA_W +: DATA_W]
- InData  in  NUM_IN*DATA_W  input channel data, same packing
- InValid  in  NUM_IN  one-cycle capture pulses per channel
- GamePad  in  PAD_W  asynchronous button levels
- Irq  out  1  registered: any channel valid or any pad edge flag set

## Operation
- Register map (offset from BASE_ADDR), NREG = NUM_OUT+NUM_IN+3:
  - 0..NUM_OUT-1: OUT[k], R/W.
  - NUM_OUT+j: IN[j], read-only; a read returns captured data and clears valid[j].
  - STATUS (NUM_OUT+NUM_IN): [NUM_IN-1:0] valid, [2*NUM_IN-1:NUM_IN] overrun, rest 0; writing 1 to an overrun bit clears it (W1C), valid bits ignore writes.
  - PAD_LEVEL (+1): synchronised pad level, zero-extended, read-only.
  - PAD_EDGE (+2): sticky rising-edge flags, W1C.
- Writes to read-only registers ignored. Accesses with Hit=0 ignored; RValid stays 0.
- Capture: InValid[j] loads IN[j] and sets valid[j]. If valid[j] already 1 and not being cleared this cycle, data is overwritten and overrun[j] set.
- Gamepad: two-flop synchroniser, then edge = sync & ~prev; edge sets PAD_EDGE bit.
- Simultaneous events:
  - Read of IN[j] with InValid[j]: RData gets old data; new data captured; valid[j] stays 1; no overrun.
  - W1C of overrun/edge bit with new set event same cycle: set wins.
  - ReadEn and WriteEn same cycle, same register: write takes effect, RData returns pre-write value.

## Timing
- Reset (synchronous): OutRegs, IN data, valid, overrun, sync flops, PAD_EDGE, RData, RValid, Irq all 0.
- Write: visible on OutRegs the cycle after WriteEn.
- Read: RData/RValid valid exactly one cycle after ReadEn; RData holds value until next accepted read.
- Capture to valid bit: 1 cycle; to Irq: 2 cycles.
- Pad press to PAD_EDGE set: 3 cycles (2 sync + edge register).
- Reset asserted mid-access: pending read is dropped, RValid 0 next cycle.

## Structure
- Package mmio_pkg: offset functions (OFF_STATUS, OFF_PAD_LEVEL, OFF_PAD_EDGE as functions of NUM_OUT/NUM_IN), NREG computation, parameter range checks.
- Sub-module mmio_in_channel (data reg, valid, overrun, read-clear/set priority), generated NUM_IN times.

## Test plan
- Reset then write 16'h1234 to OUT[1] (Addr FF01) -> OutRegs[31:16]=16'h1234 next cycle; read FF01 -> RData 16'h1234, RValid 1 one cycle later.
- InValid[0] pulse with 16'h00AB -> STATUS read 16'h0001; read FF02 -> 16'h00AB; STATUS then 16'h0000.
- Two InValid[1] pulses without read -> STATUS 16'h000A; write 16'h0008 to STATUS -> 16'h0002.
- Read IN[0] in same cycle as new InValid[0] (16'h0055) -> RData old value, valid[0]=1, overrun 0, next read 16'h0055.
- GamePad bit 3 rises -> PAD_EDGE 16'h0008 after 3 cycles, Irq 1; W1C 16'h0008 -> PAD_EDGE 0, Irq 0.
- Read Addr FEFF / FF00+NREG -> Hit 0, RValid 0; Reset mid-read -> RValid 0, all registers 0.
